regfile_mp: RTL and testbench
=============================

// Module: regfile_mp
// PURPOSE
// - Next-generation integer register file for the 5-stage RV32 pipeline: parametrised read/write port counts and depth.
// - Optional write-to-read bypass (removes the WB->ID forwarding path); register 0 optionally hardwired to zero.
// - Sequential clear engine zeroes the array after reset or on request, one register per cycle, signalled by o_busy.
// - Sits between decode (read ports) and writeback (write ports); read-only debug port for the bench/trace.
// PARAMETERS
// - DATA_WIDTH  32  register width in bits
// - ADDR_WIDTH  5   address width; depth = 2**ADDR_WIDTH
// - NUM_RD      2   number of read ports, 1..4
// - NUM_WR      1   number of write ports, 1..2
// - BYPASS      1   1: a read of an address written this cycle returns the write data
// - ZERO_REG    1   1: address 0 reads 0 and ignores writes
// PORTS
// - clk         in   1                    clock, rising edge
// - rst         in   1                    reset, asynchronous, active-high
// - i_clear     in   1                    one-cycle pulse: restart the clear engine
// - i_rs        in   NUM_RD*ADDR_WIDTH    read addresses; port k = bits [k*ADDR_WIDTH +: ADDR_WIDTH]
// - o_rdata     out  NUM_RD*DATA_WIDTH    read data, combinational, packed the same way as i_rs
// - i_rd        in   NUM_WR*ADDR_WIDTH    write addresses
// - i_wdata     in   NUM_WR*DATA_WIDTH    write data
// - i_we        in   NUM_WR               per-port write enable
// - o_busy      out  1                    1 while clearing; writes are dropped, reads return 0
// - i_dbg_addr  in   ADDR_WIDTH           debug read address
// - o_dbg_data  out  DATA_WIDTH           debug read data (never bypassed)
// BEHAVIOUR
// - Reset: asynchronous and active-high. rst=1 forces state CLEAR, clr_idx=0, o_busy=1. The array is not reset directly.
// - FSM CLEAR: each cycle writes 0 to mem[clr_idx] and increments clr_idx.
//   - clr_idx == 2**ADDR_WIDTH-1 -> state READY, o_busy=0 on the next cycle.
//   - A full clear takes 2**ADDR_WIDTH cycles after rst deasserts.
// - FSM READY: i_clear=1 -> CLEAR with clr_idx=0. An i_clear received during CLEAR restarts clr_idx at 0.
// - Reset mid-clear: the engine restarts from 0. Writes presented during CLEAR are lost; no error is flagged.
// - Writes (READY only): at the posedge, mem[i_rd[p]] <= i_wdata[p] when i_we[p]=1.
//   - ZERO_REG=1: address 0 is ignored.
//   - Both ports hit the same address: port 1 wins; port 0's write is dropped.
// - Reads: combinational, 0-cycle latency. o_rdata[k] = mem[i_rs[k]], with these overrides:
//   - o_busy=1 -> 0
//   - ZERO_REG=1 and i_rs[k]=0 -> 0
//   - BYPASS=1 and some i_we[p] with i_rd[p]==i_rs[k] (non-zero when ZERO_REG) -> i_wdata of the winning port
// - o_dbg_data = mem[i_dbg_addr]: raw array contents with no bypass, 0 while busy.
// - Widths: no arithmetic. Out-of-range NUM_RD/NUM_WR stops elaboration via a generate-time error.
// STRUCTURE
// - regfile_pkg: localparams RF_ST_CLEAR=1'b1, RF_ST_READY=1'b0, a default-width constant, and function rf_slice for packed-port extraction.
// - Sub-module regfile_clear_fsm: state, clr_idx, o_busy, and the clear write strobe/address.
// - The top level muxes the clear strobe against the functional write ports.
// - Storage is an unpacked reg array; read/write ports are generate loops.
// TESTING
// - Reset, then idle:
//   - o_busy=1 for exactly 32 cycles after rst falls, then 0.
//   - Every o_rdata and o_dbg_data reads 0 for all addresses.
// - Write/read, then bypass:
//   - Write 32'hDEADBEEF to x5; next cycle rs0=5 -> 32'hDEADBEEF.
//   - Same cycle, rs1=5 while writing 32'h12345678 to x5 -> o_rdata[1]=32'h12345678 (BYPASS=1).
//   - With BYPASS=0 that read returns 32'hDEADBEEF.
// - x0 protection: we=1, rd=0, wdata=32'hFFFFFFFF -> rs=0 reads 0 next cycle and in the bypass cycle.
// - Dual write (NUM_WR=2), same cycle:
//   - Both ports to x7 with 32'h1 (port 0) and 32'h2 (port 1) -> x7=32'h2.
//   - Different addresses x3/x4 -> both land.
// - Clear mid-run:
//   - Fill x1..x31 with their index; pulse i_clear -> o_busy=1 for 32 cycles.
//   - A write to x9 during the clear is dropped; all registers read 0 afterwards.
//   - Assert rst at clear cycle 10 -> the clear restarts and o_busy lasts 32 cycles from rst release.

Source files
------------

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants, state type and packed-port slicing helper for regfile_mp
package regfile_pkg;

    localparam logic RF_ST_CLEAR      = 1'b1;
    localparam logic RF_ST_READY      = 1'b0;
    localparam int   RF_DEFAULT_WIDTH = 32;

    // Upper bounds for the slicing helper; the top level refuses to elaborate beyond these
    localparam int   RF_MAX_VEC       = 256;
    localparam int   RF_MAX_FIELD     = 64;

    typedef enum logic {
        ST_READY = RF_ST_READY,
        ST_CLEAR = RF_ST_CLEAR
    } rf_state_e;

    // Extract field idx of the given width from a packed multi-port bus
    function automatic logic [RF_MAX_FIELD-1:0] rf_slice(
        input logic [RF_MAX_VEC-1:0] vec,
        input int                    idx,
        input int                    width
    );
        logic [RF_MAX_VEC-1:0] w_shifted;
        logic [RF_MAX_VEC-1:0] w_mask;
        w_shifted = vec >> (idx * width);
        w_mask    = ~({RF_MAX_VEC{1'b1}} << width);
        return RF_MAX_FIELD'(w_shifted & w_mask);
    endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// rtl/regfile_clear_fsm.sv - sequential clear engine: zeroes one register per cycle after reset or on request
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_clear,
    output logic                  o_busy,
    output logic                  o_clr_we,
    output logic [ADDR_WIDTH-1:0] o_clr_addr
);

    localparam logic [ADDR_WIDTH-1:0] IDX_LAST = '1;
    localparam logic [ADDR_WIDTH-1:0] IDX_ONE  = ADDR_WIDTH'(1);

    rf_state_e             r_state;
    logic [ADDR_WIDTH-1:0] r_clr_idx;
    logic                  r_busy;

    // Walk the array from index 0 to the top, restarting whenever a clear is requested
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_CLEAR;
            r_clr_idx <= '0;
            r_busy    <= 1'b1;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    if (i_clear) begin
                        r_clr_idx <= '0;
                    end else begin
                        r_clr_idx <= r_clr_idx + IDX_ONE;
                        if (r_clr_idx == IDX_LAST) begin
                            r_state <= ST_READY;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                ST_READY: begin
                    if (i_clear) begin
                        r_state   <= ST_CLEAR;
                        r_clr_idx <= '0;
                        r_busy    <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= ST_CLEAR;
                    r_clr_idx <= '0;
                    r_busy    <= 1'b1;
                end
            endcase
        end
    end

    assign o_busy     = r_busy;
    assign o_clr_we   = r_busy;
    assign o_clr_addr = r_clr_idx;

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port integer register file with bypass, hardwired x0 and clear engine
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = RF_DEFAULT_WIDTH,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_RD     = 2,
    parameter int NUM_WR     = 1,
    parameter int BYPASS     = 1,
    parameter int ZERO_REG   = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_clear,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] i_rs,
    output logic [NUM_RD*DATA_WIDTH-1:0] o_rdata,
    input  logic [NUM_WR*ADDR_WIDTH-1:0] i_rd,
    input  logic [NUM_WR*DATA_WIDTH-1:0] i_wdata,
    input  logic [NUM_WR-1:0]            i_we,
    output logic                         o_busy,
    input  logic [ADDR_WIDTH-1:0]        i_dbg_addr,
    output logic [DATA_WIDTH-1:0]        o_dbg_data
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    if (NUM_RD < 1 || NUM_RD > 4) begin : g_bad_num_rd
        $error("regfile_mp: NUM_RD must be 1..4");
    end
    if (NUM_WR < 1 || NUM_WR > 2) begin : g_bad_num_wr
        $error("regfile_mp: NUM_WR must be 1..2");
    end
    if (DATA_WIDTH > RF_MAX_FIELD || NUM_RD * DATA_WIDTH > RF_MAX_VEC) begin : g_bad_width
        $error("regfile_mp: DATA_WIDTH too large for port slicing");
    end

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  w_busy;
    logic                  w_clr_we;
    logic [ADDR_WIDTH-1:0] w_clr_addr;

    logic [NUM_WR-1:0]     w_wr_hit;
    logic [ADDR_WIDTH-1:0] w_wr_addr [NUM_WR];
    logic [DATA_WIDTH-1:0] w_wr_data [NUM_WR];

    regfile_clear_fsm #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_clear_fsm (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (i_clear),
        .o_busy     (w_busy),
        .o_clr_we   (w_clr_we),
        .o_clr_addr (w_clr_addr)
    );

    // A write port hits only when enabled and not aimed at a hardwired x0
    for (genvar p = 0; p < NUM_WR; p++) begin : g_wr
        assign w_wr_addr[p] = ADDR_WIDTH'(rf_slice(RF_MAX_VEC'(i_rd), p, ADDR_WIDTH));
        assign w_wr_data[p] = DATA_WIDTH'(rf_slice(RF_MAX_VEC'(i_wdata), p, DATA_WIDTH));
        assign w_wr_hit[p]  = i_we[p] && !((ZERO_REG != 0) && (w_wr_addr[p] == '0));
    end

    // Clear strobe owns the array while busy; otherwise higher-numbered write ports win collisions
    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[w_clr_addr] <= '0;
        end else begin
            for (int p = 0; p < NUM_WR; p++) begin
                if (w_wr_hit[p]) begin
                    r_mem[w_wr_addr[p]] <= w_wr_data[p];
                end
            end
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_WIDTH-1:0] w_rs;
        logic [DATA_WIDTH-1:0] w_rd_val;

        assign w_rs = ADDR_WIDTH'(rf_slice(RF_MAX_VEC'(i_rs), k, ADDR_WIDTH));

        // Array read, overridden by same-cycle write data (last port wins), x0 and busy
        always_comb begin
            w_rd_val = r_mem[w_rs];
            for (int p = 0; p < NUM_WR; p++) begin
                if ((BYPASS != 0) && w_wr_hit[p] && (w_wr_addr[p] == w_rs)) begin
                    w_rd_val = w_wr_data[p];
                end
            end
            if ((ZERO_REG != 0) && (w_rs == '0)) begin
                w_rd_val = '0;
            end
            if (w_busy) begin
                w_rd_val = '0;
            end
        end

        assign o_rdata[k*DATA_WIDTH +: DATA_WIDTH] = w_rd_val;
    end

    assign o_busy     = w_busy;
    assign o_dbg_data = w_busy ? '0 : r_mem[i_dbg_addr];

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - randomized and directed self-checking bench for regfile_mp against an array model
module tb_regfile_mp;

    logic        clk;
    logic        rst;
    logic        i_clear;
    logic [9:0]  i_rs;
    logic [63:0] o_rdata;
    logic [9:0]  i_rd;
    logic [63:0] i_wdata;
    logic [1:0]  i_we;
    logic        o_busy;
    logic [4:0]  i_dbg_addr;
    logic [31:0] o_dbg_data;

    int passed = 0;
    int total  = 0;

    logic [31:0] m_mem [32];
    int          m_busy_cnt = 32;

    regfile_mp #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (5),
        .NUM_RD     (2),
        .NUM_WR     (2),
        .BYPASS     (1),
        .ZERO_REG   (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (i_clear),
        .i_rs       (i_rs),
        .o_rdata    (o_rdata),
        .i_rd       (i_rd),
        .i_wdata    (i_wdata),
        .i_we       (i_we),
        .o_busy     (o_busy),
        .i_dbg_addr (i_dbg_addr),
        .o_dbg_data (o_dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic model_zero();
        for (int a = 0; a < 32; a++) m_mem[a] = 32'h0;
    endtask

    function automatic logic [31:0] exp_read(input logic [4:0] a);
        logic [31:0] v;
        if (m_busy_cnt > 0 || a == 5'd0) return 32'h0;
        v = m_mem[a];
        for (int p = 0; p < 2; p++)
            if (i_we[p] && i_rd[p*5 +: 5] == a) v = i_wdata[p*32 +: 32];
        return v;
    endfunction

    function automatic logic [31:0] exp_dbg(input logic [4:0] a);
        if (m_busy_cnt > 0) return 32'h0;
        return m_mem[a];
    endfunction

    // What the register file should look like after one rising edge
    task automatic model_edge();
        if (rst) begin
            m_busy_cnt = 32;
            model_zero();
        end else begin
            if (m_busy_cnt == 0)
                for (int p = 0; p < 2; p++)
                    if (i_we[p] && i_rd[p*5 +: 5] != 5'd0)
                        m_mem[i_rd[p*5 +: 5]] = i_wdata[p*32 +: 32];
            if (i_clear) begin
                m_busy_cnt = 32;
                model_zero();
            end else if (m_busy_cnt > 0) begin
                m_busy_cnt--;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".busy"}, {31'h0, o_busy}, {31'h0, m_busy_cnt > 0});
        chk({tag, ".rdata0"}, o_rdata[31:0], exp_read(i_rs[4:0]));
        chk({tag, ".rdata1"}, o_rdata[63:32], exp_read(i_rs[9:5]));
        chk({tag, ".dbg"}, o_dbg_data, exp_dbg(i_dbg_addr));
    endtask

    task automatic step(input string tag);
        #1;
        check_all(tag);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_wr(input int p, input logic [4:0] a, input logic [31:0] d);
        i_rd[p*5 +: 5]     = a;
        i_wdata[p*32 +: 32] = d;
    endtask

    task automatic rand_reads();
        i_rs       = 10'($urandom);
        i_dbg_addr = 5'($urandom);
    endtask

    // Count cycles until o_busy drops; write_at>=0 injects a write to x9 at that clear cycle
    task automatic busy_len(input string tag, input int write_at, output int n);
        n = 0;
        while (o_busy === 1'b1 && n < 100) begin
            rand_reads();
            i_we = 2'b00;
            if (n == write_at) begin
                i_we = 2'b01;
                set_wr(0, 5'd9, 32'h0000_0999);
            end
            step(tag);
            n++;
        end
        i_we = 2'b00;
    endtask

    task automatic sweep(input string tag);
        for (int a = 0; a < 32; a++) begin
            i_rs       = {5'(31 - a), 5'(a)};
            i_dbg_addr = 5'(a);
            step(tag);
        end
    endtask

    int n;

    initial begin
        rst = 1'b1; i_clear = 1'b0; i_rs = '0; i_rd = '0; i_wdata = '0; i_we = '0; i_dbg_addr = '0;
        model_zero();
        repeat (3) step("in_reset");
        rst = 1'b0;
        busy_len("reset_clear", -1, n);
        chk("busy_len_after_reset", 32'(n), 32'd32);
        sweep("idle_sweep");

        // Write then read, then bypass against a raw debug read
        i_we = 2'b01; set_wr(0, 5'd5, 32'hDEADBEEF); i_rs = '0;
        step("write_x5");
        i_we = 2'b00; i_rs = {5'd0, 5'd5};
        #1 chk("read_x5", o_rdata[31:0], 32'hDEADBEEF);
        step("read_x5_step");
        i_we = 2'b01; set_wr(0, 5'd5, 32'h12345678); i_rs = {5'd5, 5'd0}; i_dbg_addr = 5'd5;
        #1 chk("bypass_x5", o_rdata[63:32], 32'h12345678);
        chk("dbg_no_bypass", o_dbg_data, 32'hDEADBEEF);
        step("bypass_step");

        // x0 stays zero
        i_we = 2'b01; set_wr(0, 5'd0, 32'hFFFFFFFF); i_rs = {5'd0, 5'd0}; i_dbg_addr = 5'd0;
        #1 chk("x0_bypass", o_rdata[31:0], 32'h0);
        step("x0_write");
        i_we = 2'b00;
        #1 chk("x0_after", o_rdata[31:0], 32'h0);
        chk("x0_dbg", o_dbg_data, 32'h0);

        // Dual-port collision and independent writes
        i_we = 2'b11; set_wr(0, 5'd7, 32'h1); set_wr(1, 5'd7, 32'h2); i_rs = {5'd7, 5'd0};
        #1 chk("dual_bypass_x7", o_rdata[63:32], 32'h2);
        step("dual_x7");
        i_we = 2'b00; i_rs = {5'd0, 5'd7};
        #1 chk("dual_x7", o_rdata[31:0], 32'h2);
        i_we = 2'b11; set_wr(0, 5'd3, 32'h33); set_wr(1, 5'd4, 32'h44);
        step("dual_x3_x4");
        i_we = 2'b00; i_rs = {5'd4, 5'd3};
        #1 chk("dual_x3", o_rdata[31:0], 32'h33);
        chk("dual_x4", o_rdata[63:32], 32'h44);

        // Random traffic with frequent address collisions and occasional clears
        for (int c = 0; c < 300; c++) begin
            rand_reads();
            i_we = 2'($urandom);
            for (int p = 0; p < 2; p++)
                set_wr(p, ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom), $urandom);
            i_clear = ($urandom_range(0, 59) == 0);
            step("random");
        end
        i_clear = 1'b0;
        busy_len("random_drain", -1, n);
        chk("random_drain_bounded", {31'h0, o_busy}, 32'h0);

        // Fill x1..x31 with their index, then clear with a dropped write inside
        for (int a = 1; a < 32; a++) begin
            i_we = 2'b01; set_wr(0, 5'(a), 32'(a)); rand_reads();
            step("fill");
        end
        i_we = 2'b00; i_rs = {5'd31, 5'd9};
        #1 chk("fill_x9", o_rdata[31:0], 32'd9);
        chk("fill_x31", o_rdata[63:32], 32'd31);
        i_clear = 1'b1;
        step("clear_pulse");
        i_clear = 1'b0;
        busy_len("clear_run", 3, n);
        chk("busy_len_after_clear", 32'(n), 32'd32);
        i_dbg_addr = 5'd9;
        #1 chk("x9_write_dropped", o_dbg_data, 32'h0);
        sweep("post_clear_sweep");

        // Reset in the middle of a clear restarts it from index 0
        for (int a = 1; a < 32; a++) begin
            i_we = 2'b01; set_wr(0, 5'(a), 32'hA500 + 32'(a)); rand_reads();
            step("refill");
        end
        i_we = 2'b00;
        i_clear = 1'b1;
        step("clear_pulse2");
        i_clear = 1'b0;
        repeat (10) begin
            rand_reads();
            step("clear_before_rst");
        end
        rst = 1'b1;
        m_busy_cnt = 32;
        model_zero();
        step("mid_clear_rst");
        step("mid_clear_rst_hold");
        rst = 1'b0;
        busy_len("clear_after_rst", -1, n);
        chk("busy_len_after_mid_rst", 32'(n), 32'd32);
        sweep("final_sweep");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
